// File: rtl/arch_dump_pkg.sv
// Shared types for the architectural-state dump engine.
//   dump_state_t : walk sequence IDLE -> HDR -> REG -> MEM -> FIN -> IDLE
//   dump_tag_t   : word type carried on the output stream
//   idx_width()  : width of the per-phase index, sized for the longest phase
package arch_dump_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        REG  = 3'd2,
        MEM  = 3'd3,
        FIN  = 3'd4
    } dump_state_t;

    typedef enum logic [1:0] {
        TAG_HDR = 2'd0,
        TAG_REG = 2'd1,
        TAG_MEM = 2'd2
    } dump_tag_t;

    // Index must cover both the register and memory phases; floor of 2
    // keeps the width at least one bit.
    function automatic int idx_width(input int nregs, input int nbytes);
        int m;
        m = 2;
        if (nregs > m) m = nregs;
        if (nbytes > m) m = nbytes;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/dump_trigger_ctl.sv
// Trigger and bookkeeping side of the dump engine.
//   i_trig     : external dump request (level, sampled every cycle)
//   i_idle     : dump FSM is in IDLE and can accept a start this cycle
//   o_start    : start a dump this cycle (only asserted while i_idle)
//   o_snap     : cycle stamp to place in the header of the dump being started
//   o_cycle    : free-running cycle counter since reset release
//   o_stop     : sticky, cycle budget reached
//   o_missed   : sticky, a trigger arrived while one was already pending
module dump_trigger_ctl
    import arch_dump_pkg::*;
#(
    parameter int PERIOD      = 0,
    parameter int STOP_CYCLES = 20,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_trig,
    input  logic             i_idle,
    output logic             o_start,
    output logic [CNT_W-1:0] o_snap,
    output logic [CNT_W-1:0] o_cycle,
    output logic             o_stop,
    output logic             o_missed
);

    localparam bit               STOP_EN   = (STOP_CYCLES > 0);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);

    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_pend_snap;
    logic             r_pend;
    logic             r_stop;
    logic             r_missed;
    logic             w_auto;
    logic             w_trig;

    // Optional periodic trigger; the counter restarts on every auto-trigger.
    generate
        if (PERIOD > 0) begin : g_period
            localparam logic [31:0] PERIOD_LAST = 32'(PERIOD - 1);
            logic [31:0] r_period;

            assign w_auto = (r_period == PERIOD_LAST);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_period <= '0;
                end else if (w_auto) begin
                    r_period <= '0;
                end else begin
                    r_period <= r_period + 32'd1;
                end
            end
        end else begin : g_no_period
            assign w_auto = 1'b0;
        end
    endgenerate

    assign w_trig  = i_trig | w_auto;
    assign o_start = i_idle & (r_pend | w_trig);
    // A pending request carries the stamp of the cycle it arrived in, so a
    // back-to-back dump reports when it was asked for, not when it began.
    assign o_snap  = r_pend ? r_pend_snap : r_cycle;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle     <= '0;
            r_pend_snap <= '0;
            r_pend      <= 1'b0;
            r_stop      <= 1'b0;
            r_missed    <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 1'b1;

            if (STOP_EN && (r_cycle == STOP_LAST)) begin
                r_stop <= 1'b1;
            end

            if (i_idle) begin
                // Pending is consumed by this start; a coincident new
                // trigger takes its place.
                if (r_pend) begin
                    r_pend <= w_trig;
                    if (w_trig) begin
                        r_pend_snap <= r_cycle;
                    end
                end
            end else if (w_trig) begin
                if (r_pend) begin
                    r_missed <= 1'b1;
                end else begin
                    r_pend      <= 1'b1;
                    r_pend_snap <= r_cycle;
                end
            end
        end
    end

    assign o_cycle  = r_cycle;
    assign o_stop   = r_stop;
    assign o_missed = r_missed;

endmodule

// File: rtl/arch_state_dumper.sv
// Architectural-state dump engine.
// Streams a header (cycle stamp), every register-file entry, then the first
// DUMP_BYTES bytes of data memory on a valid/ready interface.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   trig_i                : dump request
//   rf_raddr_o/rf_rdata_i : asynchronous register-file read port
//   dm_raddr_o/dm_rdata_i : asynchronous data-memory byte read port
//   out_valid_o/out_ready_i/out_tag_o/out_idx_o/out_data_o : output stream
//   busy_o, done_o, missed_o, cycle_o, stop_o : status
module arch_state_dumper
    import arch_dump_pkg::*;
#(
    parameter  int NUM_REGS    = 32,
    parameter  int REG_W       = 32,
    parameter  int MEM_AW      = 7,
    parameter  int DUMP_BYTES  = 32,
    parameter  int PERIOD      = 0,
    parameter  int STOP_CYCLES = 20,
    parameter  int CNT_W       = 32,
    localparam int IDX_W       = idx_width(NUM_REGS, DUMP_BYTES),
    localparam int RF_AW       = $clog2(NUM_REGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             trig_i,
    output logic [RF_AW-1:0] rf_raddr_o,
    input  logic [REG_W-1:0] rf_rdata_i,
    output logic [MEM_AW-1:0] dm_raddr_o,
    input  logic [7:0]       dm_rdata_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       out_tag_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic [REG_W-1:0] out_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             missed_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic             stop_o
);

    localparam logic [IDX_W-1:0] LAST_REG  = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM  = IDX_W'((DUMP_BYTES > 0) ? DUMP_BYTES - 1 : 0);
    localparam dump_state_t      AFTER_REG = (DUMP_BYTES > 0) ? MEM : FIN;

    dump_state_t      r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_snap;
    logic             r_out_valid;
    logic [1:0]       r_out_tag;
    logic [IDX_W-1:0] r_out_idx;
    logic [REG_W-1:0] r_out_data;
    logic             r_done;
    logic             r_busy;

    logic              w_load;
    logic              w_start;
    logic [CNT_W-1:0]  w_snap;
    logic [REG_W-1:0]  w_hdr_data;
    logic [REG_W-1:0]  w_mem_data;
    logic [MEM_AW-1:0] w_dm_idx;

    dump_trigger_ctl #(
        .PERIOD      (PERIOD),
        .STOP_CYCLES (STOP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_trig (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_trig   (trig_i),
        .i_idle   (r_state == IDLE),
        .o_start  (w_start),
        .o_snap   (w_snap),
        .o_cycle  (cycle_o),
        .o_stop   (stop_o),
        .o_missed (missed_o)
    );

    // Output register is free when empty or being drained this cycle.
    assign w_load = !r_out_valid || out_ready_i;

    generate
        if (REG_W > CNT_W) begin : g_hdr_pad
            assign w_hdr_data = {{(REG_W - CNT_W){1'b0}}, r_snap};
        end else begin : g_hdr_trunc
            assign w_hdr_data = r_snap[REG_W-1:0];
        end

        if (MEM_AW > IDX_W) begin : g_dm_pad
            assign w_dm_idx = {{(MEM_AW - IDX_W){1'b0}}, r_idx};
        end else begin : g_dm_trunc
            assign w_dm_idx = r_idx[MEM_AW-1:0];
        end
    endgenerate

    assign w_mem_data = {{(REG_W - 8){1'b0}}, dm_rdata_i};

    // r_idx only advances on a load, so the address (and hence the
    // combinational read data) is stable until the next load samples it.
    assign rf_raddr_o = (r_state == REG) ? r_idx[RF_AW-1:0] : '0;
    assign dm_raddr_o = (r_state == MEM) ? w_dm_idx : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_snap      <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Drained with nothing new to load; states below override.
            if (w_load) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_snap  <= w_snap;
                        r_idx   <= '0;
                        r_state <= HDR;
                        r_busy  <= 1'b1;
                    end
                end
                HDR: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_tag   <= TAG_HDR;
                        r_out_idx   <= '0;
                        r_out_data  <= w_hdr_data;
                        r_idx       <= '0;
                        r_state     <= REG;
                    end
                end
                REG: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_tag   <= TAG_REG;
                        r_out_idx   <= r_idx;
                        r_out_data  <= rf_rdata_i;
                        if (r_idx == LAST_REG) begin
                            r_idx   <= '0;
                            r_state <= AFTER_REG;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                MEM: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_tag   <= TAG_MEM;
                        r_out_idx   <= r_idx;
                        r_out_data  <= w_mem_data;
                        if (r_idx == LAST_MEM) begin
                            r_idx   <= '0;
                            r_state <= FIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                FIN: begin
                    // Wait for the last word to leave, then pulse done.
                    if (w_load) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_tag_o   = r_out_tag;
    assign out_idx_o   = r_out_idx;
    assign out_data_o  = r_out_data;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule
